// File: rtl/sync_iis_tx_port_if.sv
// Bundle of the serial audio transmitter's control, FIFO and line signals.
// master = transmitter side, slave = register block / FIFO / line side.
interface sync_iis_tx_port_if;
  logic        tx_en;
  logic [1:0]  regmap_iis_bitsnum;
  logic [1:0]  regmap_iis_port_sel;
  logic        regmap_iis_offset;
  logic        fifo_empty;
  logic [31:0] fifo_left_data;
  logic [31:0] fifo_right_data;
  logic        fifo_rd_en;
  logic        sck;
  logic        lrclk;
  logic        sdout;
  logic        underflow;
  logic        busy;

  modport master (
    input  tx_en,
    input  regmap_iis_bitsnum,
    input  regmap_iis_port_sel,
    input  regmap_iis_offset,
    input  fifo_empty,
    input  fifo_left_data,
    input  fifo_right_data,
    output fifo_rd_en,
    output sck,
    output lrclk,
    output sdout,
    output underflow,
    output busy
  );

  modport slave (
    output tx_en,
    output regmap_iis_bitsnum,
    output regmap_iis_port_sel,
    output regmap_iis_offset,
    output fifo_empty,
    output fifo_left_data,
    output fifo_right_data,
    input  fifo_rd_en,
    input  sck,
    input  lrclk,
    input  sdout,
    input  underflow,
    input  busy
  );
endinterface

// File: rtl/sync_iis_tx_port.sv
// Clock-master serial audio transmitter: 64-sck frames in IIS/LJ/RJ/TDM,
// one left/right pair fetched from the output FIFO per frame.
module sync_iis_tx_port #(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sync_iis_tx_port_if.master  bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] FMT_IIS = 2'd0;
  localparam logic [1:0] FMT_RJ  = 2'd2;
  localparam logic [1:0] FMT_TDM = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [5:0]        slot_q, slot_d;
  logic              sck_q, sck_d;
  logic              lrclk_q, lrclk_d;
  logic              sdout_q, sdout_d;
  logic              rd_en_q, rd_en_d;
  logic              underflow_q, underflow_d;
  logic              busy_q, busy_d;
  logic [1:0]        ps_q, ps_d;
  logic [1:0]        bn_q, bn_d;
  logic              off_q, off_d;
  logic [31:0]       act_l_q, act_l_d;
  logic [31:0]       act_r_q, act_r_d;
  logic [31:0]       hold_l_q, hold_l_d;
  logic [31:0]       hold_r_q, hold_r_d;
  logic [1:0]        fstage_q, fstage_d;
  logic              fok_q, fok_d;

  // Serial bit for slot s: locate the slot inside the left or right word window.
  function automatic logic slot_bit(input logic [5:0] s, input logic [1:0] ps,
                                    input logic [1:0] bn, input logic [31:0] l,
                                    input logic [31:0] r);
    logic [6:0] w;
    logic [6:0] sl;
    logic [6:0] sr;
    logic [6:0] s7;
    logic [4:0] k;
    logic       b;
    w  = (bn == 2'd3) ? 7'd32 : 7'd16 + {3'b000, bn, 2'b00};
    s7 = {1'b0, s};
    case (ps)
      FMT_RJ:  begin sl = 7'd32 - w; sr = 7'd64 - w; end
      FMT_TDM: begin sl = 7'd0;      sr = w;         end
      default: begin sl = 7'd0;      sr = 7'd32;     end
    endcase
    b = 1'b0;
    k = 5'd0;
    if ((s7 >= sl) && (s7 < sl + w)) begin
      k = 5'(7'd31 - (s7 - sl));
      b = l[k];
    end else if ((s7 >= sr) && (s7 < sr + w)) begin
      k = 5'(7'd31 - (s7 - sr));
      b = r[k];
    end
    return b;
  endfunction

  function automatic logic slot_lr(input logic [5:0] s, input logic [1:0] ps,
                                   input logic off);
    logic v;
    case (ps)
      FMT_IIS: v = (s >= 6'd31) && (s <= 6'd62);
      FMT_TDM: v = off ? (s == 6'd63) : (s == 6'd0);
      default: v = ~s[5];
    endcase
    return v;
  endfunction

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    slot_d      = slot_q;
    sck_d       = sck_q;
    lrclk_d     = lrclk_q;
    sdout_d     = sdout_q;
    rd_en_d     = 1'b0;
    underflow_d = 1'b0;
    busy_d      = busy_q;
    ps_d        = ps_q;
    bn_d        = bn_q;
    off_d       = off_q;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    fstage_d    = fstage_q;
    fok_d       = fok_q;

    // Fetch pipeline: pop pulse, then FIFO data valid, then capture into holding.
    case (fstage_q)
      2'd1: fstage_d = 2'd2;
      2'd2: begin
        fstage_d = 2'd0;
        hold_l_d = fok_q ? bus.fifo_left_data  : 32'd0;
        hold_r_d = fok_q ? bus.fifo_right_data : 32'd0;
      end
      default: fstage_d = 2'd0;
    endcase

    case (state_q)
      ST_IDLE: begin
        sck_d   = 1'b1;
        sdout_d = 1'b0;
        busy_d  = 1'b0;
        lrclk_d = (bus.regmap_iis_port_sel == FMT_IIS);
        if (bus.tx_en) begin
          state_d     = ST_PRELOAD;
          busy_d      = 1'b1;
          ps_d        = bus.regmap_iis_port_sel;
          bn_d        = bus.regmap_iis_bitsnum;
          off_d       = bus.regmap_iis_offset;
          div_d       = '0;
          slot_d      = 6'd63;
          rd_en_d     = ~bus.fifo_empty;
          underflow_d = bus.fifo_empty;
          fok_d       = ~bus.fifo_empty;
          fstage_d    = 2'd1;
        end
      end

      ST_PRELOAD: begin
        if (fstage_q == 2'd2) begin
          state_d = ST_RUN;
          div_d   = '0;
        end
      end

      ST_RUN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else if ((slot_q == 6'd63) && !bus.tx_en) begin
            state_d = ST_IDLE;
            sck_d   = 1'b1;
            sdout_d = 1'b0;
            busy_d  = 1'b0;
            lrclk_d = (bus.regmap_iis_port_sel == FMT_IIS);
          end else begin
            sck_d  = 1'b0;
            slot_d = slot_q + 6'd1;
            if (slot_d == 6'd0) begin
              ps_d    = bus.regmap_iis_port_sel;
              bn_d    = bus.regmap_iis_bitsnum;
              off_d   = bus.regmap_iis_offset;
              act_l_d = hold_l_q;
              act_r_d = hold_r_q;
            end
            if (slot_d == 6'd63) begin
              if (bus.tx_en) begin
                rd_en_d     = ~bus.fifo_empty;
                underflow_d = bus.fifo_empty;
                fok_d       = ~bus.fifo_empty;
                fstage_d    = 2'd1;
              end else begin
                // A suppressed fetch leaves silence queued in case tx_en returns.
                hold_l_d = 32'd0;
                hold_r_d = 32'd0;
              end
            end
            sdout_d = slot_bit(slot_d, ps_d, bn_d, act_l_d, act_r_d);
            lrclk_d = slot_lr(slot_d, ps_d, off_d);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      slot_q      <= 6'd63;
      sck_q       <= 1'b1;
      lrclk_q     <= 1'b0;
      sdout_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
      ps_q        <= 2'd0;
      bn_q        <= 2'd0;
      off_q       <= 1'b0;
      act_l_q     <= 32'd0;
      act_r_q     <= 32'd0;
      hold_l_q    <= 32'd0;
      hold_r_q    <= 32'd0;
      fstage_q    <= 2'd0;
      fok_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      slot_q      <= slot_d;
      sck_q       <= sck_d;
      lrclk_q     <= lrclk_d;
      sdout_q     <= sdout_d;
      rd_en_q     <= rd_en_d;
      underflow_q <= underflow_d;
      busy_q      <= busy_d;
      ps_q        <= ps_d;
      bn_q        <= bn_d;
      off_q       <= off_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      fstage_q    <= fstage_d;
      fok_q       <= fok_d;
    end
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.sck        = sck_q;
  assign bus.lrclk      = lrclk_q;
  assign bus.sdout      = sdout_q;
  assign bus.underflow  = underflow_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sync_iis_tx_port.sv
// Bench for sync_iis_tx_port: FIFO model, frame-aligned receiver and a
// word-placement reference model of the 64-slot frame.
module tb_sync_iis_tx_port;
  localparam int CLK_DIV = 2;

  logic clk;
  logic rst_n;
  sync_iis_tx_port_if bus();

  sync_iis_tx_port #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // FIFO model: data presented the cycle after a pop request.
  logic [31:0] fq_l[$];
  logic [31:0] fq_r[$];
  always @(negedge clk) begin
    if (bus.fifo_rd_en && fq_l.size() > 0) begin
      bus.fifo_left_data  = fq_l.pop_front();
      bus.fifo_right_data = fq_r.pop_front();
    end
    bus.fifo_empty = (fq_l.size() == 0);
  end

  // Receiver: slot advances on each sck fall, bits sampled on each sck rise.
  int          frame_cnt = 0;
  int          mon_slot = 63;
  bit          mon_act = 1'b0;
  logic        prev_sck = 1'b1;
  int          cyc = 0;
  int          last_fall = 0;
  int          per_err = 0;
  int          rd_cnt = 0;
  int          uf_cnt = 0;
  logic [63:0] cur_sd;
  logic [63:0] cur_lr;
  logic [63:0] fr_sd[0:127];
  logic [63:0] fr_lr[0:127];

  always @(negedge clk) begin
    cyc++;
    if (bus.fifo_rd_en) rd_cnt++;
    if (bus.underflow) uf_cnt++;
    if (!bus.busy) begin
      mon_slot = 63;
      mon_act  = 1'b0;
    end else if (prev_sck && !bus.sck) begin
      if (mon_act && (cyc - last_fall) != 2 * CLK_DIV) per_err++;
      last_fall = cyc;
      mon_act   = 1'b1;
      mon_slot  = (mon_slot + 1) % 64;
    end else if (!prev_sck && bus.sck && mon_act) begin
      cur_sd[mon_slot] = bus.sdout;
      cur_lr[mon_slot] = bus.lrclk;
      if (mon_slot == 63 && frame_cnt < 128) begin
        fr_sd[frame_cnt] = cur_sd;
        fr_lr[frame_cnt] = cur_lr;
        frame_cnt++;
      end
    end
    prev_sck = bus.sck;
  end

  // Reference model: where each word sits in the 64-slot frame.
  function automatic void geom(input logic [1:0] ps, input logic [1:0] bn,
                               output int w, output int sl, output int sr);
    case (bn)
      2'd0: w = 16;
      2'd1: w = 20;
      2'd2: w = 24;
      default: w = 32;
    endcase
    case (ps)
      2'd2:    begin sl = 32 - w; sr = 64 - w; end
      2'd3:    begin sl = 0;      sr = w;      end
      default: begin sl = 0;      sr = 32;     end
    endcase
  endfunction

  function automatic void build_frame(input logic [1:0] ps, input logic [1:0] bn,
                                      input logic off, input logic [31:0] l,
                                      input logic [31:0] r, output logic [63:0] sd,
                                      output logic [63:0] lr);
    int w, sl, sr;
    geom(ps, bn, w, sl, sr);
    sd = 64'd0;
    lr = 64'd0;
    for (int i = 0; i < w; i++) begin
      sd[sl + i] = l[31 - i];
      sd[sr + i] = r[31 - i];
    end
    case (ps)
      2'd0: for (int s = 31; s <= 62; s++) lr[s] = 1'b1;
      2'd3: lr[off ? 63 : 0] = 1'b1;
      default: lr[31:0] = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] decode(input logic [63:0] sd, input int start, input int w);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < w; i++) v[31 - i] = sd[start + i];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input int idx, input logic [1:0] ps, input logic [1:0] bn,
                             input logic off, input logic [31:0] l, input logic [31:0] r,
                             input string tag);
    logic [63:0] sd, lr;
    build_frame(ps, bn, off, l, r, sd, lr);
    check($sformatf("%s_sdout", tag), fr_sd[idx], sd);
    check($sformatf("%s_lrclk", tag), fr_lr[idx], lr);
    $display("frame %0d %s ps=%0d bn=%0d off=%0d sd=%h lr=%h", idx, tag, ps, bn, off,
             fr_sd[idx], fr_lr[idx]);
  endtask

  task automatic wait_window(input int fbase, input int k, input int lo, input int hi,
                             input string what);
    int n;
    n = 0;
    while (!((frame_cnt - fbase) == k && mon_act && mon_slot >= lo && mon_slot <= hi)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s actual=expired required=reached", what);
    end
  endtask

  task automatic wait_idle(input string what);
    int n;
    n = 0;
    while (bus.busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s actual=busy required=idle", what);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic set_cfg(input logic [1:0] ps, input logic [1:0] bn, input logic off);
    bus.regmap_iis_port_sel = ps;
    bus.regmap_iis_bitsnum  = bn;
    bus.regmap_iis_offset   = off;
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_sck", tag),   64'(bus.sck),        64'd1);
    check($sformatf("%s_lrclk", tag), 64'(bus.lrclk),      64'd0);
    check($sformatf("%s_sdout", tag), 64'(bus.sdout),      64'd0);
    check($sformatf("%s_rd_en", tag), 64'(bus.fifo_rd_en), 64'd0);
    check($sformatf("%s_uflow", tag), 64'(bus.underflow),  64'd0);
    check($sformatf("%s_busy", tag),  64'(bus.busy),       64'd0);
  endtask

  typedef struct {
    logic [1:0]  ps;
    logic [1:0]  bn;
    logic        off;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int fb, rb, ub, pb, w, sl, sr;
    logic [1:0]  rps[4];
    logic [1:0]  rbn[4];
    logic        roff[4];
    logic [31:0] rl[4];
    logic [31:0] rr[4];

    tbl[0] = '{2'd0, 2'd0, 1'b0, 32'hA5A5_0000, 32'h5A5A_0000, 32'hA5A5_0000, 32'h5A5A_0000};
    tbl[1] = '{2'd1, 2'd2, 1'b0, 32'h1234_5678, 32'hABCD_EF12, 32'h1234_5600, 32'hABCD_EF00};
    tbl[2] = '{2'd2, 2'd1, 1'b0, 32'hFFFF_F000, 32'h1357_9BDF, 32'hFFFF_F000, 32'h1357_9000};
    tbl[3] = '{2'd3, 2'd3, 1'b1, 32'h8000_0001, 32'h0000_0003, 32'h8000_0001, 32'h0000_0003};
    tbl[4] = '{2'd3, 2'd0, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hDEAD_0000, 32'hCAFE_0000};
    tbl[5] = '{2'd0, 2'd3, 1'b0, 32'h0123_4567, 32'h89AB_CDEF, 32'h0123_4567, 32'h89AB_CDEF};

    rst_n = 1'b0;
    bus.tx_en = 1'b0;
    set_cfg(2'd0, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    repeat (2) @(negedge clk);
    check("idle_lrclk_iis", 64'(bus.lrclk), 64'd1);
    set_cfg(2'd1, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("idle_lrclk_lj", 64'(bus.lrclk), 64'd0);

    // Table: one pair per vector, tx_en dropped early so exactly one frame goes out.
    for (int v = 0; v < 6; v++) begin
      set_cfg(tbl[v].ps, tbl[v].bn, tbl[v].off);
      fq_l.push_back(tbl[v].l);
      fq_r.push_back(tbl[v].r);
      repeat (2) @(negedge clk);
      fb = frame_cnt; rb = rd_cnt; ub = uf_cnt; pb = per_err;
      bus.tx_en = 1'b1;
      wait_window(fb, 0, 5, 20, $sformatf("vec%0d", v));
      bus.tx_en = 1'b0;
      wait_idle($sformatf("vec%0d_idle", v));
      check($sformatf("vec%0d_frames", v), 64'(frame_cnt - fb), 64'd1);
      check($sformatf("vec%0d_rd_en", v),  64'(rd_cnt - rb),    64'd1);
      check($sformatf("vec%0d_uflow", v),  64'(uf_cnt - ub),    64'd0);
      check($sformatf("vec%0d_period", v), 64'(per_err - pb),   64'd0);
      check($sformatf("vec%0d_sck_idle", v), 64'(bus.sck), 64'd1);
      check_frame(fb, tbl[v].ps, tbl[v].bn, tbl[v].off, tbl[v].l, tbl[v].r,
                  $sformatf("vec%0d", v));
      geom(tbl[v].ps, tbl[v].bn, w, sl, sr);
      check($sformatf("vec%0d_rx_left", v),  64'(decode(fr_sd[fb], sl, w)), 64'(tbl[v].exp_l));
      check($sformatf("vec%0d_rx_right", v), 64'(decode(fr_sd[fb], sr, w)), 64'(tbl[v].exp_r));
    end

    // Random continuous runs; next frame's config is written mid-frame.
    for (int run = 0; run < 3; run++) begin
      for (int k = 0; k < 4; k++) begin
        rps[k]  = 2'($urandom_range(3));
        rbn[k]  = 2'($urandom_range(3));
        roff[k] = 1'($urandom_range(1));
        rl[k]   = $urandom;
        rr[k]   = $urandom;
        fq_l.push_back(rl[k]);
        fq_r.push_back(rr[k]);
      end
      set_cfg(rps[0], rbn[0], roff[0]);
      repeat (2) @(negedge clk);
      fb = frame_cnt; rb = rd_cnt; ub = uf_cnt; pb = per_err;
      bus.tx_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
        wait_window(fb, k, 20, 40, $sformatf("rnd%0d_f%0d", run, k));
        if (k < 3) set_cfg(rps[k + 1], rbn[k + 1], roff[k + 1]);
        else bus.tx_en = 1'b0;
      end
      wait_idle($sformatf("rnd%0d_idle", run));
      check($sformatf("rnd%0d_frames", run), 64'(frame_cnt - fb), 64'd4);
      check($sformatf("rnd%0d_rd_en", run),  64'(rd_cnt - rb),    64'd4);
      check($sformatf("rnd%0d_uflow", run),  64'(uf_cnt - ub),    64'd0);
      check($sformatf("rnd%0d_period", run), 64'(per_err - pb),   64'd0);
      for (int k = 0; k < 4; k++)
        check_frame(fb + k, rps[k], rbn[k], roff[k], rl[k], rr[k],
                    $sformatf("rnd%0d_f%0d", run, k));
    end

    // Underflow: FIFO empty at the second fetch, refilled during the silent frame.
    set_cfg(2'd1, 2'd3, 1'b0);
    fq_l.push_back(32'h1111_2222);
    fq_r.push_back(32'h3333_4444);
    repeat (2) @(negedge clk);
    fb = frame_cnt; rb = rd_cnt; ub = uf_cnt;
    bus.tx_en = 1'b1;
    wait_window(fb, 1, 5, 20, "uf_f1");
    fq_l.push_back(32'h5555_6666);
    fq_r.push_back(32'h7777_8888);
    wait_window(fb, 2, 10, 12, "uf_f2_slot10");
    bus.tx_en = 1'b0;
    wait_idle("uf_idle");
    check("uf_frames", 64'(frame_cnt - fb), 64'd3);
    check("uf_rd_en",  64'(rd_cnt - rb),    64'd2);
    check("uf_pulses", 64'(uf_cnt - ub),    64'd1);
    check("uf_sck_idle",  64'(bus.sck),  64'd1);
    check("uf_busy_idle", 64'(bus.busy), 64'd0);
    check_frame(fb,     2'd1, 2'd3, 1'b0, 32'h1111_2222, 32'h3333_4444, "uf_f0");
    check_frame(fb + 1, 2'd1, 2'd3, 1'b0, 32'd0,         32'd0,         "uf_f1_zero");
    check_frame(fb + 2, 2'd1, 2'd3, 1'b0, 32'h5555_6666, 32'h7777_8888, "uf_f2");

    // Reset at slot 40, then restart from PRELOAD with the next pair.
    set_cfg(2'd0, 2'd2, 1'b0);
    fq_l.push_back(32'h0BAD_F00D);
    fq_r.push_back(32'h0D15_EA5E);
    fq_l.push_back(32'hC0FF_EE00);
    fq_r.push_back(32'h00FA_CADE);
    repeat (2) @(negedge clk);
    rb = rd_cnt;
    bus.tx_en = 1'b1;
    wait_window(frame_cnt, 0, 40, 42, "rst_slot40");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fb = frame_cnt;
    wait_window(fb, 0, 20, 30, "rst_restart");
    bus.tx_en = 1'b0;
    wait_idle("rst_idle");
    check("rst_frames", 64'(frame_cnt - fb), 64'd1);
    check("rst_rd_en",  64'(rd_cnt - rb),    64'd2);
    check_frame(fb, 2'd0, 2'd2, 1'b0, 32'hC0FF_EE00, 32'h00FA_CADE, "rst_f0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_iis_tx_port.md
Name: sync_iis_tx_port

Overview:
- Serial audio transmitter (clock master) for the DAC output path.
- Pulls one left/right sample pair per frame from the output FIFO and generates sck and lrclk.
- Serializes the pair on sdout in IIS, left-justified, right-justified or TDM/DSP format, for 16/20/24/32-bit words.
- Frame is fixed at 64 sck; a frame-aligned receiver captures the words back unchanged.

Parameters:
- CLK_DIV, 4, clk cycles per sck half-period; legal values are >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- tx_en  input  1  transmitter enable
- regmap_iis_bitsnum  input  2  word length: 0=16, 1=20, 2=24, 3=32
- regmap_iis_port_sel  input  2  format: 0=IIS, 1=LJ, 2=RJ, 3=TDM
- regmap_iis_offset  input  1  TDM only: 1 = one-sck sync offset
- fifo_empty  input  1  output FIFO empty
- fifo_left_data  input  32  left sample, MSB-justified; valid the clk after fifo_rd_en
- fifo_right_data  input  32  right sample, MSB-justified; valid the clk after fifo_rd_en
- fifo_rd_en  output  1  one-clk FIFO pop pulse
- sck  output  1  serial bit clock
- lrclk  output  1  word select / frame sync
- sdout  output  1  serial data
- underflow  output  1  one-clk pulse: FIFO was empty at fetch time
- busy  output  1  high outside IDLE

Behaviour:
- All outputs are registered.
- Reset values: sck=1, lrclk=0, sdout=0, fifo_rd_en=0, underflow=0, busy=0, FSM=IDLE.
- Reset mid-operation returns everything to these values immediately; the sample in flight is discarded.
- Config latch: port_sel, bitsnum and offset are latched into shadow registers when leaving IDLE and at every slot-63 to slot-0 boundary. Mid-frame register changes never affect the current frame.
- FSM IDLE:
  - sck=1, sdout=0.
  - lrclk idles at 1 if IIS, else 0, using live port_sel.
  - tx_en=1 moves to PRELOAD.
- FSM PRELOAD:
  - One fetch: if !fifo_empty, fifo_rd_en=1 for one clk and data is loaded the next clk.
  - If fifo_empty, load zeros and pulse underflow.
  - Then RUN; slot 0 starts CLK_DIV clks later on the first sck falling edge.
- FSM RUN:
  - div counter 0..CLK_DIV-1 toggles sck at terminal count.
  - Each sck falling edge advances slot 0..63 (wrap).
  - On the same clk edge as each sck falling edge, lrclk and sdout update to the new slot's values.
  - Receiver samples on sck rising edge.
- Fetch in RUN:
  - On the clk where slot 63 begins, fetch as in PRELOAD into a holding register.
  - Holding register transfers to the active shift pair at slot 0.
  - Exactly one fetch per frame.
- Underflow: the frame is sent as all zeros; transmission continues and the next frame fetches normally.
- Slot map, W = word length; bits are sent MSB first from bit 31 downward:
  - LJ: lrclk=1 on slots 0..31. Left on slots 0..W-1, right on slots 32..31+W.
  - RJ: lrclk=1 on slots 0..31. Left on slots 32-W..31, right on slots 64-W..63.
  - IIS: lrclk=0 on slots 63 and 0..30, 1 on slots 31..62. Left on slots 0..W-1, right on slots 32..31+W.
  - TDM: lrclk=1 for one slot only, slot 63 if offset=1 else slot 0. Left on slots 0..W-1, right on slots W..2W-1.
  - All other slots drive sdout=0.
- Width rule: bits below 32-W of the input word are never transmitted.
- tx_en deassert: the current frame completes through slot 63, then IDLE. No fetch is issued at that slot 63.
- tx_en reasserted before slot 63 ends keeps RUN seamless.
- Simultaneous tx_en=0 with a fetch slot: the fetch is suppressed.
- busy=1 in PRELOAD and RUN.

Test Plan:
- IIS, 16-bit, CLK_DIV=2, left=0xA5A50000, right=0x5A5A0000 -> sck period 4 clk, frame 256 clk. lrclk falls at slot 63. sdout slots 0..15 = A5A5, 32..47 = 5A5A, others 0. One fifo_rd_en per frame.
- LJ 24-bit, left=0x123456xx, right=0xABCDEFxx -> lrclk high slots 0..31. Slots 0..23 = 0x123456, slots 32..55 = 0xABCDEF. Low byte never appears.
- RJ 20-bit, left=0xFFFFF000 -> left bits on slots 12..31, slots 0..11 = 0. Loopback through the receiver returns 0xFFFFF000.
- TDM offset=1, 32-bit, left=0x80000001, right=0x00000003 -> lrclk one-slot pulse at slot 63. Slot 0 = 1, slot 31 = 1, slots 62..63 = 1. Offset=0 moves the pulse to slot 0.
- fifo_empty=1 at a fetch -> underflow one-clk pulse, no fifo_rd_en, whole frame zeros. The following frame carries the next FIFO pair.
- tx_en=0 at slot 10 -> frame finishes slot 63, then sck=1, busy=0. Reset at slot 40 -> all outputs at reset values within 1 clk; restart from PRELOAD.
